// File: rtl/dm_port_arbiter.sv
// Round-robin arbiter sharing the single-ported data memory between the core
// instruction controller and the program/data loader; all outputs registered.
module dm_port_arbiter #(
   parameter int MemSize    = 10,
   parameter int DataSize   = 32,
   parameter int DM_LATENCY = 1,
   parameter int CntSize    = 16
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                core_req,
   input  logic                core_write,
   input  logic [MemSize-1:0]  core_addr,
   input  logic [DataSize-1:0] core_wdata,
   output logic                core_gnt,
   output logic                core_done,
   output logic [DataSize-1:0] core_rdata,
   input  logic                ld_req,
   input  logic                ld_write,
   input  logic [MemSize-1:0]  ld_addr,
   input  logic [DataSize-1:0] ld_wdata,
   output logic                ld_gnt,
   output logic                ld_done,
   output logic [DataSize-1:0] ld_rdata,
   output logic                dm_enable,
   output logic                dm_fetch,
   output logic                dm_write,
   output logic [MemSize-1:0]  dm_address,
   output logic [DataSize-1:0] dm_in,
   input  logic [DataSize-1:0] dm_out,
   output logic                busy,
   output logic [CntSize-1:0]  conflict_cnt
);

   typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DONE} state_t;

   localparam logic [2:0] WAIT_INIT = 3'(DM_LATENCY - 1);

   state_t     state_reg, state_next;
   logic       owner_reg, owner_next;       // 1 = loader owns the current access
   logic       write_reg, write_next;
   logic       last_ld_reg;                 // 1 = loader won the previous arbitration
   logic [2:0] wait_cnt_reg;
   logic       start, conflict, sel_ld, capture;

   always_comb begin
      state_next = state_reg;
      start      = 1'b0;
      conflict   = 1'b0;
      sel_ld     = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (core_req && ld_req) begin
               start    = 1'b1;
               conflict = 1'b1;
               sel_ld   = ~last_ld_reg;
            end else if (core_req) begin
               start = 1'b1;
            end else if (ld_req) begin
               start  = 1'b1;
               sel_ld = 1'b1;
            end
            if (start)
               state_next = ST_ISSUE;
         end
         ST_ISSUE: state_next = write_reg ? ST_DONE : ST_WAIT;
         ST_WAIT:  if (wait_cnt_reg == 3'd0) state_next = ST_DONE;
         ST_DONE:  state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
      owner_next = start ? sel_ld : owner_reg;
      write_next = start ? (sel_ld ? ld_write : core_write) : write_reg;
      capture    = (state_reg == ST_WAIT) && (wait_cnt_reg == 3'd0);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_reg    <= ST_IDLE;
         owner_reg    <= 1'b0;
         write_reg    <= 1'b0;
         last_ld_reg  <= 1'b1;
         wait_cnt_reg <= 3'd0;
         core_gnt     <= 1'b0;
         core_done    <= 1'b0;
         core_rdata   <= '0;
         ld_gnt       <= 1'b0;
         ld_done      <= 1'b0;
         ld_rdata     <= '0;
         dm_enable    <= 1'b0;
         dm_fetch     <= 1'b0;
         dm_write     <= 1'b0;
         dm_address   <= '0;
         dm_in        <= '0;
         busy         <= 1'b0;
         conflict_cnt <= '0;
      end else begin
         state_reg <= state_next;
         owner_reg <= owner_next;
         write_reg <= write_next;

         if (start) begin
            last_ld_reg <= sel_ld;
            dm_address  <= sel_ld ? ld_addr  : core_addr;
            dm_in       <= sel_ld ? ld_wdata : core_wdata;
         end

         if (conflict && (conflict_cnt != {CntSize{1'b1}}))
            conflict_cnt <= conflict_cnt + 1'b1;

         // Latency countdown is loaded on entry to ISSUE and runs down in WAIT
         if (state_next == ST_ISSUE)
            wait_cnt_reg <= WAIT_INIT;
         else if ((state_reg == ST_WAIT) && (wait_cnt_reg != 3'd0))
            wait_cnt_reg <= wait_cnt_reg - 3'd1;

         if (capture) begin
            if (owner_reg)
               ld_rdata <= dm_out;
            else
               core_rdata <= dm_out;
         end

         dm_enable <= (state_next == ST_ISSUE);
         dm_fetch  <= (state_next == ST_ISSUE) && !write_next;
         dm_write  <= (state_next == ST_ISSUE) &&  write_next;
         busy      <= (state_next != ST_IDLE);
         core_gnt  <= (state_next != ST_IDLE) && !owner_next;
         ld_gnt    <= (state_next != ST_IDLE) &&  owner_next;
         core_done <= (state_next == ST_DONE) && !owner_next;
         ld_done   <= (state_next == ST_DONE) &&  owner_next;
      end
   end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed bench for dm_port_arbiter: one instance at DM_LATENCY=1, one at
// DM_LATENCY=3 with a 2-bit conflict counter, each backed by a small DM model.
`timescale 1ns/1ps
module tb_dm_port_arbiter;
   localparam int MS = 10;
   localparam int DS = 32;

   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   int n_cmp = 0;
   int n_err = 0;

   // instance A: DM_LATENCY=1
   logic          core_req_a = 0, core_write_a = 0, ld_req_a = 0, ld_write_a = 0;
   logic [MS-1:0] core_addr_a = '0, ld_addr_a = '0;
   logic [DS-1:0] core_wdata_a = '0, ld_wdata_a = '0;
   logic          core_gnt_a, core_done_a, ld_gnt_a, ld_done_a;
   logic [DS-1:0] core_rdata_a, ld_rdata_a, dm_in_a, dm_out_a;
   logic          dm_enable_a, dm_fetch_a, dm_write_a, busy_a;
   logic [MS-1:0] dm_address_a;
   logic [15:0]   conflict_cnt_a;

   // instance B: DM_LATENCY=3, CntSize=2
   logic          core_req_b = 0, core_write_b = 0, ld_req_b = 0, ld_write_b = 0;
   logic [MS-1:0] core_addr_b = '0, ld_addr_b = '0;
   logic [DS-1:0] core_wdata_b = '0, ld_wdata_b = '0;
   logic          core_gnt_b, core_done_b, ld_gnt_b, ld_done_b;
   logic [DS-1:0] core_rdata_b, ld_rdata_b, dm_in_b, dm_out_b;
   logic          dm_enable_b, dm_fetch_b, dm_write_b, busy_b;
   logic [MS-1:0] dm_address_b;
   logic [1:0]    conflict_cnt_b;

   dm_port_arbiter #(.MemSize(MS), .DataSize(DS), .DM_LATENCY(1), .CntSize(16)) u_dut_a (
      .clock(clock), .reset(reset),
      .core_req(core_req_a), .core_write(core_write_a), .core_addr(core_addr_a),
      .core_wdata(core_wdata_a), .core_gnt(core_gnt_a), .core_done(core_done_a),
      .core_rdata(core_rdata_a),
      .ld_req(ld_req_a), .ld_write(ld_write_a), .ld_addr(ld_addr_a),
      .ld_wdata(ld_wdata_a), .ld_gnt(ld_gnt_a), .ld_done(ld_done_a),
      .ld_rdata(ld_rdata_a),
      .dm_enable(dm_enable_a), .dm_fetch(dm_fetch_a), .dm_write(dm_write_a),
      .dm_address(dm_address_a), .dm_in(dm_in_a), .dm_out(dm_out_a),
      .busy(busy_a), .conflict_cnt(conflict_cnt_a)
   );

   dm_port_arbiter #(.MemSize(MS), .DataSize(DS), .DM_LATENCY(3), .CntSize(2)) u_dut_b (
      .clock(clock), .reset(reset),
      .core_req(core_req_b), .core_write(core_write_b), .core_addr(core_addr_b),
      .core_wdata(core_wdata_b), .core_gnt(core_gnt_b), .core_done(core_done_b),
      .core_rdata(core_rdata_b),
      .ld_req(ld_req_b), .ld_write(ld_write_b), .ld_addr(ld_addr_b),
      .ld_wdata(ld_wdata_b), .ld_gnt(ld_gnt_b), .ld_done(ld_done_b),
      .ld_rdata(ld_rdata_b),
      .dm_enable(dm_enable_b), .dm_fetch(dm_fetch_b), .dm_write(dm_write_b),
      .dm_address(dm_address_b), .dm_in(dm_in_b), .dm_out(dm_out_b),
      .busy(busy_b), .conflict_cnt(conflict_cnt_b)
   );

   // DM models: read data appears DM_LATENCY cycles after the fetch cycle, zero otherwise
   logic [DS-1:0] mem_a [0:1023];
   logic [DS-1:0] mem_b [0:1023];
   logic [DS-1:0] pipe_a = '0;
   logic [DS-1:0] pipe_b0 = '0, pipe_b1 = '0, pipe_b2 = '0;

   always @(posedge clock) begin
      if (dm_enable_a && dm_write_a) mem_a[dm_address_a] <= dm_in_a;
      pipe_a <= (dm_enable_a && dm_fetch_a) ? mem_a[dm_address_a] : '0;
      if (dm_enable_b && dm_write_b) mem_b[dm_address_b] <= dm_in_b;
      pipe_b0 <= (dm_enable_b && dm_fetch_b) ? mem_b[dm_address_b] : '0;
      pipe_b1 <= pipe_b0;
      pipe_b2 <= pipe_b1;
   end
   assign dm_out_a = pipe_a;
   assign dm_out_b = pipe_b2;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   initial begin
      int         nd;
      logic [3:0] order;

      // reset state
      repeat (2) @(posedge clock);
      #1;
      chk("rst_busy", 32'(busy_a), 0);
      chk("rst_core_gnt", 32'(core_gnt_a), 0);
      chk("rst_dm_enable", 32'(dm_enable_a), 0);
      chk("rst_dm_address", 32'(dm_address_a), 0);
      chk("rst_conflict", 32'(conflict_cnt_a), 0);
      chk("rst_core_rdata", core_rdata_a, 0);
      reset = 1'b1;
      tick();

      // 1: core read of address 5
      mem_a[5] = 32'hDEADBEEF;
      core_req_a = 1; core_write_a = 0; core_addr_a = 10'h005;
      tick();
      chk("t1_issue_fetch", 32'(dm_fetch_a), 1);
      chk("t1_issue_enable", 32'(dm_enable_a), 1);
      chk("t1_issue_write", 32'(dm_write_a), 0);
      chk("t1_issue_addr", 32'(dm_address_a), 32'h005);
      chk("t1_core_gnt", 32'(core_gnt_a), 1);
      chk("t1_ld_gnt", 32'(ld_gnt_a), 0);
      tick();
      chk("t1_wait_fetch", 32'(dm_fetch_a), 0);
      chk("t1_wait_done", 32'(core_done_a), 0);
      chk("t1_wait_busy", 32'(busy_a), 1);
      tick();
      chk("t1_core_done", 32'(core_done_a), 1);
      chk("t1_core_rdata", core_rdata_a, 32'hDEADBEEF);
      chk("t1_ld_rdata", ld_rdata_a, 0);
      chk("t1_ld_done", 32'(ld_done_a), 0);
      $display("txn core read  addr=0x005 rdata=0x%08h", core_rdata_a);
      core_req_a = 0;
      tick();
      chk("t1_done_clear", 32'(core_done_a), 0);
      chk("t1_idle_busy", 32'(busy_a), 0);

      // 2: loader write to top address, then core readback
      ld_req_a = 1; ld_write_a = 1; ld_addr_a = 10'h3FF; ld_wdata_a = 32'h12345678;
      tick();
      chk("t2_dm_write", 32'(dm_write_a), 1);
      chk("t2_dm_fetch", 32'(dm_fetch_a), 0);
      chk("t2_dm_address", 32'(dm_address_a), 32'h3FF);
      chk("t2_dm_in", dm_in_a, 32'h12345678);
      chk("t2_ld_gnt", 32'(ld_gnt_a), 1);
      chk("t2_core_gnt", 32'(core_gnt_a), 0);
      tick();
      chk("t2_ld_done", 32'(ld_done_a), 1);
      chk("t2_write_drop", 32'(dm_write_a), 0);
      chk("t2_enable_drop", 32'(dm_enable_a), 0);
      chk("t2_addr_hold", 32'(dm_address_a), 32'h3FF);
      chk("t2_core_rdata_kept", core_rdata_a, 32'hDEADBEEF);
      chk("t2_ld_rdata_kept", ld_rdata_a, 0);
      $display("txn ld   write addr=0x3ff wdata=0x12345678");
      ld_req_a = 0;
      tick();
      chk("t2_mem_written", mem_a[10'h3FF], 32'h12345678);
      core_req_a = 1; core_write_a = 0; core_addr_a = 10'h3FF;
      repeat (3) tick();
      chk("t2_readback_done", 32'(core_done_a), 1);
      chk("t2_readback", core_rdata_a, 32'h12345678);
      $display("txn core read  addr=0x3ff rdata=0x%08h", core_rdata_a);
      core_req_a = 0;
      tick();

      // 3: simultaneous requests after reset, held for four transactions
      reset = 0;
      tick();
      reset = 1;
      tick();
      core_req_a = 1; core_write_a = 0; core_addr_a = 10'h005;
      ld_req_a = 1; ld_write_a = 0; ld_addr_a = 10'h3FF;
      nd = 0; order = '0;
      for (int c = 0; c < 40 && nd < 4; c++) begin
         tick();
         chk("t3_gnt_exclusive", 32'(core_gnt_a & ld_gnt_a), 0);
         if (core_done_a) begin
            order = {order[2:0], 1'b0};
            chk("t3_core_rdata", core_rdata_a, 32'hDEADBEEF);
            $display("txn core read  addr=0x005 rdata=0x%08h", core_rdata_a);
            nd++;
         end
         if (ld_done_a) begin
            order = {order[2:0], 1'b1};
            chk("t3_ld_rdata", ld_rdata_a, 32'h12345678);
            $display("txn ld   read  addr=0x3ff rdata=0x%08h", ld_rdata_a);
            nd++;
         end
         if (nd == 4) begin
            core_req_a = 0;
            ld_req_a = 0;
         end
      end
      core_req_a = 0; ld_req_a = 0;
      chk("t3_done_count", 32'(nd), 4);
      chk("t3_grant_order", 32'(order), 32'b0101);
      tick();
      chk("t3_conflict_cnt", 32'(conflict_cnt_a), 4);
      chk("t3_idle_busy", 32'(busy_a), 0);

      // 4: reset during WAIT aborts the read
      core_req_a = 1; core_write_a = 0; core_addr_a = 10'h005;
      tick();
      tick();
      chk("t4_in_wait", 32'(busy_a), 1);
      reset = 0;
      #1;
      chk("t4_enable", 32'(dm_enable_a), 0);
      chk("t4_core_gnt", 32'(core_gnt_a), 0);
      chk("t4_busy", 32'(busy_a), 0);
      chk("t4_conflict", 32'(conflict_cnt_a), 0);
      chk("t4_core_rdata", core_rdata_a, 0);
      chk("t4_ld_rdata", ld_rdata_a, 0);
      chk("t4_dm_address", 32'(dm_address_a), 0);
      chk("t4_dm_in", dm_in_a, 0);
      core_req_a = 0;
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("t4_no_done", 32'(core_done_a), 0);
      end
      reset = 1;
      tick();
      chk("t4_post_busy", 32'(busy_a), 0);
      chk("t4_post_conflict", 32'(conflict_cnt_a), 0);
      chk("t4_post_done", 32'(core_done_a), 0);
      $display("txn core read  aborted by reset");

      // 5: DM_LATENCY=3 read with req dropped in ISSUE
      mem_b[7] = 32'hCAFEF00D;
      core_req_b = 1; core_write_b = 0; core_addr_b = 10'h007;
      tick();
      chk("t5_issue_fetch", 32'(dm_fetch_b), 1);
      core_req_b = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t5_wait_no_done", 32'(core_done_b), 0);
         chk("t5_wait_busy", 32'(busy_b), 1);
      end
      tick();
      chk("t5_core_done", 32'(core_done_b), 1);
      chk("t5_core_rdata", core_rdata_b, 32'hCAFEF00D);
      $display("txn core read  addr=0x007 rdata=0x%08h (latency 3)", core_rdata_b);
      tick();
      chk("t5_idle_busy", 32'(busy_b), 0);

      // 5b: five conflicts on a 2-bit counter saturate at 3
      core_req_b = 1; core_write_b = 1; core_addr_b = 10'h001; core_wdata_b = 32'h1;
      ld_req_b = 1; ld_write_b = 1; ld_addr_b = 10'h002; ld_wdata_b = 32'h2;
      nd = 0;
      for (int c = 0; c < 60 && nd < 5; c++) begin
         tick();
         chk("t5_gnt_exclusive", 32'(core_gnt_b & ld_gnt_b), 0);
         if (core_done_b || ld_done_b) begin
            nd++;
            $display("txn %s write conflict_cnt=%0d", core_done_b ? "core" : "ld  ", conflict_cnt_b);
            if (nd == 2) chk("t5_conflict_two", 32'(conflict_cnt_b), 2);
         end
         if (nd == 5) begin
            core_req_b = 0;
            ld_req_b = 0;
         end
      end
      core_req_b = 0; ld_req_b = 0;
      chk("t5_done_count", 32'(nd), 5);
      tick();
      chk("t5_conflict_sat", 32'(conflict_cnt_b), 3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
